// File: rtl/nt_mon_pkg.sv
// Shared types, default widths and helpers for the Nt-node activity monitor.
package nt_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ALARM = 2'd2
   } state_e;

   localparam int DEF_WIN_W   = 8;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_STAMP_W = 16;

   // Callers zero-extend to 32 bits and pass their all-ones ceiling as max_val.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val,
                                           input logic        inc);
      return (inc && (val != max_val)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/nt_sat_counter.sv
// Saturating up-counter with synchronous clear (highest priority) and hold.
module nt_sat_counter
   import nt_mon_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         inc,
   input  logic         hold,
   output logic [W-1:0] count
);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (!hold) begin
         count <= W'(sat_inc(32'(count), 32'({W{1'b1}}), inc));
      end
   end

endmodule

// File: rtl/nt_node_activity_monitor.sv
// Windowed hit/toggle monitor for a single Nt-node output with latched,
// time-stamped alarm when a window's hit count reaches the threshold.
//
//   state | meaning
//   IDLE  | not monitoring; counters show the last values
//   COUNT | sampling node_s into the current window
//   ALARM | threshold reached; counters and stamp frozen until alarm_ack
module nt_node_activity_monitor
   import nt_mon_pkg::*;
#(
   parameter int WIN_W   = DEF_WIN_W,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int STAMP_W = DEF_STAMP_W
) (
   input  logic               I1470,
   input  logic               I1477,
   input  logic               node_in,
   input  logic               en,
   input  logic [WIN_W-1:0]   window_len,
   input  logic [CNT_W-1:0]   threshold,
   input  logic               alarm_ack,
   output logic               alarm,
   output logic [CNT_W-1:0]   hit_count,
   output logic [CNT_W-1:0]   toggle_count,
   output logic [STAMP_W-1:0] stamp,
   output logic               busy
);

   state_e             state;
   state_e             state_nxt;
   logic               node_s;
   logic               prev_node;
   logic [WIN_W-1:0]   win_pos;
   logic [WIN_W-1:0]   win_last;
   logic [STAMP_W-1:0] cyc;
   logic [CNT_W-1:0]   hit_nxt;
   logic               win_close;
   logic               cnt_clr;
   logic               cnt_hold;
   logic               pos_clr;
   logic               alarm_set;
   logic               alarm_clr;

   // A zero length behaves as a one-cycle window.
   assign win_last  = (window_len == '0) ? '0 : window_len - 1'b1;
   assign win_close = (win_pos == win_last);
   assign hit_nxt   = CNT_W'(sat_inc(32'(hit_count), 32'({CNT_W{1'b1}}), node_s));
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_hold  = 1'b1;
      pos_clr   = 1'b0;
      alarm_set = 1'b0;
      alarm_clr = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = COUNT;
               cnt_clr   = 1'b1;
               pos_clr   = 1'b1;
            end
         end
         COUNT: begin
            if (!en) begin
               state_nxt = IDLE;
            end else begin
               cnt_hold = 1'b0;
               // The closing sample is counted before the threshold decision.
               if (win_close) begin
                  if (hit_nxt >= threshold) begin
                     state_nxt = ALARM;
                     alarm_set = 1'b1;
                  end else begin
                     cnt_clr = 1'b1;
                     pos_clr = 1'b1;
                  end
               end
            end
         end
         ALARM: begin
            if (alarm_ack) begin
               alarm_clr = 1'b1;
               if (en) begin
                  state_nxt = COUNT;
                  cnt_clr   = 1'b1;
                  pos_clr   = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge I1470 or negedge I1477) begin
      if (!I1477) begin
         state     <= IDLE;
         node_s    <= 1'b0;
         prev_node <= 1'b0;
         cyc       <= '0;
         win_pos   <= '0;
         alarm     <= 1'b0;
         stamp     <= '0;
      end else begin
         state     <= state_nxt;
         node_s    <= node_in;
         prev_node <= node_s;
         cyc       <= cyc + 1'b1;
         if (pos_clr) begin
            win_pos <= '0;
         end else if ((state == COUNT) && en) begin
            win_pos <= win_pos + 1'b1;
         end
         if (alarm_set) begin
            alarm <= 1'b1;
            stamp <= cyc;
         end else if (alarm_clr) begin
            alarm <= 1'b0;
         end
      end
   end

   nt_sat_counter #(.W(CNT_W)) u_hit_cnt (
      .clk_sys (I1470),
      .rst_b   (I1477),
      .clr     (cnt_clr),
      .inc     (node_s),
      .hold    (cnt_hold),
      .count   (hit_count)
   );

   nt_sat_counter #(.W(CNT_W)) u_tog_cnt (
      .clk_sys (I1470),
      .rst_b   (I1477),
      .clr     (cnt_clr),
      .inc     (node_s ^ prev_node),
      .hold    (cnt_hold),
      .count   (toggle_count)
   );

endmodule

// File: tb/tb_nt_node_activity_monitor.sv
// Directed-vector bench for nt_node_activity_monitor plus a narrow-counter
// instance for saturation.
module tb_nt_node_activity_monitor;

   logic        clk;
   logic        rst_n, en, node_in, alarm_ack;
   logic [7:0]  window_len, threshold;
   logic        alarm, busy;
   logic [7:0]  hit_count, toggle_count;
   logic [15:0] stamp;

   logic        rst2, en2, node2, ack2;
   logic [7:0]  wl2;
   logic [3:0]  th2;
   logic        alarm2, busy2;
   logic [3:0]  hit2, tog2;
   logic [15:0] stamp2;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic        rst_n, en, node, ack;
      logic [7:0]  wl, th;
      logic        e_alarm, e_busy;
      logic [7:0]  e_hit, e_tog;
      logic [15:0] e_stamp;
   } vec_t;

   vec_t vecs[$];

   nt_node_activity_monitor dut (
      .I1470        (clk),
      .I1477        (rst_n),
      .node_in      (node_in),
      .en           (en),
      .window_len   (window_len),
      .threshold    (threshold),
      .alarm_ack    (alarm_ack),
      .alarm        (alarm),
      .hit_count    (hit_count),
      .toggle_count (toggle_count),
      .stamp        (stamp),
      .busy         (busy)
   );

   nt_node_activity_monitor #(.WIN_W(8), .CNT_W(4), .STAMP_W(16)) dut_sat (
      .I1470        (clk),
      .I1477        (rst2),
      .node_in      (node2),
      .en           (en2),
      .window_len   (wl2),
      .threshold    (th2),
      .alarm_ack    (ack2),
      .alarm        (alarm2),
      .hit_count    (hit2),
      .toggle_count (tog2),
      .stamp        (stamp2),
      .busy         (busy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic r, e, n, a, input logic [7:0] wl, th,
                      input logic ea, eb, input logic [7:0] eh, et,
                      input logic [15:0] es);
      vec_t v;
      v.rst_n = r; v.en = e; v.node = n; v.ack = a; v.wl = wl; v.th = th;
      v.e_alarm = ea; v.e_busy = eb; v.e_hit = eh; v.e_tog = et; v.e_stamp = es;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int edges;
      logic seen;

      rst_n = 1'b0; en = 1'b0; node_in = 1'b0; alarm_ack = 1'b0;
      window_len = 8'd4; threshold = 8'd3;
      rst2 = 1'b0; en2 = 1'b0; node2 = 1'b0; ack2 = 1'b0;
      wl2 = 8'd40; th2 = 4'd15;

      // cyc after row k's edge equals k, so a stamp raised on row k reads k-1
      //  rst en nd ack wl th   alarm busy hit tog stamp
      add(0, 0, 0, 0, 4, 3,  0, 0, 0, 0, 0);
      add(1, 0, 1, 0, 4, 3,  0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 4, 3,  0, 1, 0, 0, 0);   // enter COUNT, prev=1
      add(1, 1, 1, 0, 4, 3,  0, 1, 1, 0, 0);
      add(1, 1, 0, 0, 4, 3,  0, 1, 2, 0, 0);
      add(1, 1, 1, 0, 4, 3,  0, 1, 2, 1, 0);
      add(1, 1, 0, 0, 4, 3,  1, 1, 3, 2, 5);   // close: 1,1,0,1 -> alarm
      for (int i = 0; i < 10; i++)
         add(1, logic'(i % 2), 0, 0, 4, 3,  1, 1, 3, 2, 5);
      add(1, 1, 1, 1, 4, 3,  0, 1, 0, 0, 5);   // ack with en -> COUNT
      add(1, 1, 0, 0, 4, 3,  0, 1, 1, 1, 5);
      add(1, 1, 0, 0, 4, 3,  0, 1, 1, 2, 5);
      add(1, 1, 1, 0, 4, 3,  0, 1, 1, 2, 5);
      add(1, 1, 1, 0, 4, 3,  0, 1, 0, 0, 5);   // 1,0,0,1 -> no alarm, restart
      add(1, 1, 1, 0, 4, 3,  0, 1, 1, 0, 5);
      add(1, 1, 1, 0, 8, 3,  0, 1, 2, 0, 5);
      add(1, 0, 0, 0, 8, 3,  0, 0, 2, 0, 5);   // abort at position 2 of 8
      add(1, 0, 0, 0, 8, 3,  0, 0, 2, 0, 5);
      add(1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 5);
      add(1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 26);  // threshold 0 alarms at close
      add(1, 1, 1, 1, 0, 0,  0, 1, 0, 0, 26);
      add(1, 1, 1, 0, 0, 1,  1, 1, 1, 1, 28);
      add(1, 0, 1, 1, 0, 1,  0, 0, 1, 1, 28);  // ack with en=0 -> IDLE
      add(1, 0, 1, 1, 0, 1,  0, 0, 1, 1, 28);  // ack ignored in IDLE
      add(1, 1, 1, 0, 0, 1,  0, 1, 0, 0, 28);
      add(1, 1, 1, 0, 0, 1,  1, 1, 1, 0, 32);

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n; en = vecs[i].en; node_in = vecs[i].node;
         alarm_ack = vecs[i].ack; window_len = vecs[i].wl; threshold = vecs[i].th;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d alarm", i), 32'(alarm), 32'(vecs[i].e_alarm));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d hit", i), 32'(hit_count), 32'(vecs[i].e_hit));
         chk($sformatf("v%0d tog", i), 32'(toggle_count), 32'(vecs[i].e_tog));
         chk($sformatf("v%0d stamp", i), 32'(stamp), 32'(vecs[i].e_stamp));
      end

      // Asynchronous reset while the alarm is pending.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst alarm", 32'(alarm), 32'd0);
      chk("async_rst busy", 32'(busy), 32'd0);
      chk("async_rst hit", 32'(hit_count), 32'd0);
      chk("async_rst stamp", 32'(stamp), 32'd0);

      // Narrow counters: 40-cycle window, node toggling every cycle.
      @(negedge clk);
      rst2 = 1'b1;
      en2  = 1'b1;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 80) begin
         node2 = ~node2;
         @(posedge clk);
         #1;
         edges++;
         if (edges == 30) begin
            chk("sat mid hit", 32'(hit2), 32'd15);
            chk("sat mid alarm", 32'(alarm2), 32'd0);
         end
         if (alarm2) seen = 1'b1;
      end
      chk("sat alarm edge", 32'(edges), 32'd41);
      chk("sat alarm", 32'(alarm2), 32'd1);
      chk("sat hit", 32'(hit2), 32'd15);
      chk("sat tog", 32'(tog2), 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/nt_node_activity_monitor.md
Name: nt_node_activity_monitor

Overview:
- Downstream consumer of a single Nt-node subcircuit output bit (one per benchmark instance, e.g. the node15781-class output).
- Observes the node over programmable windows, counts 1-cycles (hits) and toggles, and raises a latched alarm with a cycle stamp when hits in a window reach a threshold.
- Used by the trojan-detection bench to flag rare-node activation without logging every cycle.

Parameters:
- WIN_W, 8, width of the window length and window position counter.
- CNT_W, 8, width of the hit and toggle counters. Both counters saturate.
- STAMP_W, 16, width of the free-running cycle stamp. The stamp wraps.

Ports:
- I1470  in  1  clock; all state is updated on the rising edge.
- I1477  in  1  reset, asynchronous, active-low.
- node_in  in  1  monitored node value, sampled every cycle.
- en  in  1  monitoring enable.
- window_len  in  WIN_W  window length in cycles; 0 is treated as 1.
- threshold  in  CNT_W  hit count that triggers an alarm.
- alarm_ack  in  1  clears a pending alarm.
- alarm  out  1  alarm pending.
- hit_count  out  CNT_W  hits in the current window; after an alarm, hits in the closing window.
- toggle_count  out  CNT_W  toggles in the current window; after an alarm, toggles in the closing window.
- stamp  out  STAMP_W  cycle stamp captured when the alarm was raised.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (I1477=0, asynchronous): state=IDLE; all outputs 0; win_pos=0; prev_node=0; cyc=0.
- cyc is a free-running counter of width STAMP_W. It increments every cycle in every state and wraps to 0.
- Registered sample: node_s <= node_in every cycle. All counting uses node_s, so counting lags node_in by 1 cycle.
- States:
  - IDLE: busy=0.
    - en=1 -> COUNT; clear hit_count, toggle_count and win_pos; load prev_node from node_s.
  - COUNT:
    - Each cycle: hit_count += node_s; toggle_count += (node_s != prev_node); prev_node <= node_s.
    - Both counters saturate at all-ones.
    - Window close: win_pos == max(window_len,1)-1. That cycle's sample is included in the counts.
      - Final hit count >= threshold -> ALARM; alarm<=1; stamp<=cyc; counters frozen.
      - Otherwise the window restarts next cycle: counters cleared, win_pos=0.
    - Otherwise win_pos increments.
    - en=0 in any COUNT cycle aborts -> IDLE. Counters hold their last values. No alarm is raised, even if this would have been a close cycle.
  - ALARM: alarm=1; counters and stamp held.
    - alarm_ack=1 -> alarm<=0.
      - en=1: go to COUNT with cleared counters.
      - en=0: go to IDLE.
    - en has no effect until alarm_ack arrives.
- threshold=0: an alarm is raised at every window close.
- Simultaneous en=0 and alarm_ack=1 in ALARM -> IDLE.
- Changing window_len or threshold mid-window takes effect at the next comparison. If win_pos already exceeds the new length-1, the window closes when win_pos wraps at 2^WIN_W-1. This behaviour is documented, not trapped.
- alarm_ack outside ALARM is ignored.
- Reset mid-window or during ALARM: immediate return to reset values. The alarm is lost.

Decomposition:
- Shared package nt_mon_pkg holds:
  - state enum {IDLE, COUNT, ALARM}, 2 bits;
  - a saturating-increment function;
  - default width constants.
- One natural sub-module: nt_sat_counter (parameterised width; clear, inc and hold inputs). It is instantiated twice, for hits and toggles.
- Window control, stamp and FSM stay in the top module.

Test Plan:
- Reset release, en=1, window_len=4, threshold=3, node_in=1,1,0,1 -> alarm rises on the cycle after the 4th sample is counted. hit_count=3, toggle_count=2, stamp = cyc value at close.
- Same setup with node_in=1,0,0,1 -> no alarm. Counters clear and a new window starts. busy stays 1.
- Alarm pending, hold alarm_ack=0 for 10 cycles -> outputs stable. alarm_ack=1 with en=1 -> alarm=0 next cycle and counters restart at 0.
- CNT_W=4, window_len=40, node_in toggling every cycle, threshold=15 -> hit_count and toggle_count saturate at 15. Alarm is raised at close.
- en dropped mid-window (position 2 of 8) -> IDLE, busy=0, no alarm, counters held. Assert I1477=0 during ALARM -> alarm=0 asynchronously.
- window_len=0, threshold=1, node_in=1 constant -> alarm after the 1-cycle window. threshold=0 with node_in=0 -> alarm at every window close.
